approx_adder_err_engine: RTL
============================

Name: approx_adder_err_engine

Overview:
Parametrised, synthesisable error-characterisation engine for lower-part approximate adders. On a start pulse it sweeps every operand pair (a, b) of width WIDTH and compares a selectable approximate adder against the exact sum. It accumulates ER/AE/MAE/MSE raw sums and the worst-case error, so the metrics are available on-chip or in fast gate-level sims without a software loop. It replaces per-design exhaustive benches as the common metric source for all adder drafts.

Parameters:
- WIDTH, 8, operand width W; legal range 2..12.
- APPROX_BITS, 4, number of approximated low bits K; legal range 0..WIDTH. K=0 makes every mode exact.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE or DONE
- mode  input  2  adder mode, latched when start is accepted: 0 exact, 1 LOA (OR lower part), 2 truncate, 3 lower-ones
- busy  output  1  high from the start-accept edge until done asserts
- done  output  1  one-cycle pulse when all results are final
- err_count  output  2W+1  number of cases with nonzero error
- err_sum  output  3W+2  signed sum of (approx - exact)
- abs_sum  output  3W+1  sum of |error|
- sq_sum  output  4W+2  sum of error squared
- max_abs_err  output  W+1  largest |error| seen
- total_cases  output  2W+1  cases accumulated; equals 2^(2W) at done

Behaviour:
- Reset: FSM goes to IDLE. busy, done and all result outputs go to 0. The pipeline valids clear. Reset takes priority over everything, including mid-sweep; a reset during a sweep discards that sweep.
- FSM states and transitions:
  - IDLE -> RUN when start is high.
  - RUN -> DRAIN after the last operand pair is issued.
  - DRAIN -> DONE when the pipeline is empty.
  - DONE -> RUN when start is high; otherwise DONE holds.
  - start in RUN or DRAIN is ignored. mode changes mid-sweep have no effect.
- Accepting start (IDLE or DONE): clear all accumulators, latch mode, zero the case counter, assert busy.
- Operand generation: a 2W-bit counter cnt. a = cnt[2W-1:W], b = cnt[W-1:0]. The counter increments once per cycle in RUN; cnt at 2^(2W)-1 is the last case and there is no wrap issue.
- Pipeline stage 1 (registered): the approximate sum (W+1 bits), the exact sum a+b (W+1 bits), and a valid bit.
- Pipeline stage 2 (registered): err = approx - exact as a signed (W+2)-bit value, plus |err| and err squared. The accumulators update on every valid case.
- Error-rate rule: err_count increments iff err != 0. max_abs_err updates iff |err| > max_abs_err.
- Latency: with start sampled at edge N and M = 2^(2W), done is high for exactly one cycle after edge N+M+2. busy falls at the same edge that done rises. Results hold stable until the next accepted start or reset.
- Adder modes (L = low K bits, U = high W-K bits):
  - exact: a+b.
  - LOA: low result = a[L] | b[L]; carry into U = a[K-1] & b[K-1].
  - truncate: low result = 0; carry into U = 0.
  - lower-ones: low result = all ones; carry into U = 0.
  - In modes 1-3, U = a[U] + b[U] + carry, and the final carry becomes bit W.
- Widths are sized so that no accumulator can overflow for any legal W/K; saturation logic is not required.

Decomposition:
- Package approx_err_pkg holds:
  - the mode enum: MODE_EXACT, MODE_LOA, MODE_TRUNC, MODE_ONES;
  - the FSM state enum: IDLE, RUN, DRAIN, DONE;
  - width helper functions for the accumulators.
- One sub-module: approx_add_core, purely combinational (a, b, mode -> sum[W:0], parameterised by WIDTH and APPROX_BITS). The engine instantiates it in stage 1.

Test Plan:
- W=2, K=1, mode 1, start pulse -> done after exactly 18 edges. Results: err_count=4, err_sum=+4, abs_sum=4, sq_sum=4, max_abs_err=1, total_cases=16.
- W=2, K=1, mode 2 -> err_count=12, err_sum=-16, abs_sum=16, sq_sum=24, max_abs_err=2.
- W=2, K=1, mode 3 -> err_count=8, err_sum=0, abs_sum=8, sq_sum=8, max_abs_err=1. A start pulse during RUN is ignored: no restart, and done timing is unchanged.
- W=8, K=4, mode 0, then K=0 with mode 1 -> all error outputs 0 and total_cases=65536, with done after 65538 edges.
- Reset at cycle 7 of a W=2 sweep -> the following edge shows IDLE, all outputs 0, busy=0, done=0. A fresh start then gives the same results as an uninterrupted run.
- Back-to-back sweeps: start in DONE with a different mode -> accumulators clear at the accept edge, and the new results match that mode's expected values.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types and accumulator width helpers for the approximate-adder error engine.
package approx_err_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOA   = 2'd1,
        MODE_TRUNC = 2'd2,
        MODE_ONES  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Each width leaves headroom for a full 2^(2W)-case sweep at the worst |err|.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 3 * w + 2;
    endfunction

    function automatic int abs_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int sq_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational lower-part approximate adder: exact, LOA, truncate and lower-ones modes.
module approx_add_core
    import approx_err_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  mode_e            i_mode,
    output logic [WIDTH:0]   o_sum
);
    localparam int K = APPROX_BITS;

    logic [WIDTH:0] w_exact;

    assign w_exact = {1'b0, i_a} + {1'b0, i_b};

    generate
        if (K == 0) begin : g_exact_only
            assign o_sum = w_exact;
        end else begin : g_approx
            logic [K-1:0]   w_low;
            logic           w_carry;
            logic [WIDTH:0] w_approx;

            always_comb begin
                w_low   = '0;
                w_carry = 1'b0;
                case (i_mode)
                    MODE_LOA: begin
                        w_low   = i_a[K-1:0] | i_b[K-1:0];
                        w_carry = i_a[K-1] & i_b[K-1];
                    end
                    MODE_ONES: w_low = '1;
                    default: ;
                endcase
            end

            // With every bit approximated only the carry survives above the low part.
            if (K == WIDTH) begin : g_no_upper
                assign w_approx = {w_carry, w_low};
            end else begin : g_upper
                localparam int UW = WIDTH - K;
                logic [UW:0] w_upper;
                assign w_upper  = {1'b0, i_a[WIDTH-1:K]} + {1'b0, i_b[WIDTH-1:K]}
                                + {{UW{1'b0}}, w_carry};
                assign w_approx = {w_upper, w_low};
            end

            assign o_sum = (i_mode == MODE_EXACT) ? w_exact : w_approx;
        end
    endgenerate

endmodule

// File: rtl/approx_adder_err_engine.sv
// Exhaustive error-characterisation engine: sweeps every operand pair through the
// approximate adder and accumulates error-rate, signed, absolute and squared error sums.
module approx_adder_err_engine
    import approx_err_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [1:0]                     i_mode,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [cnt_w(WIDTH)-1:0]        o_err_count,
    output logic signed [sum_w(WIDTH)-1:0] o_err_sum,
    output logic [abs_w(WIDTH)-1:0]        o_abs_sum,
    output logic [sq_w(WIDTH)-1:0]         o_sq_sum,
    output logic [WIDTH:0]                 o_max_abs_err,
    output logic [cnt_w(WIDTH)-1:0]        o_total_cases
);
    localparam int CW = cnt_w(WIDTH);
    localparam int SW = sum_w(WIDTH);
    localparam int AW = abs_w(WIDTH);
    localparam int QW = sq_w(WIDTH);
    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 2;

    localparam logic [2*WIDTH-1:0] STEP_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]     ABS_ONE  = {{WIDTH{1'b0}}, 1'b1};

    state_e             r_state;
    state_e             w_state_next;
    mode_e              r_mode;
    logic [2*WIDTH-1:0] r_cnt;
    logic               r_done;
    logic               w_done_next;
    logic               w_accept;
    logic               w_issue;
    logic               w_last;

    logic [WIDTH:0]     w_approx;
    logic [WIDTH:0]     w_exact;
    logic [WIDTH:0]     r_s1_approx;
    logic [WIDTH:0]     r_s1_exact;
    logic               r_s1_valid;

    logic [EW-1:0]      w_err;
    logic [WIDTH:0]     w_abs;
    logic [PW-1:0]      w_abs_ext;
    logic [PW-1:0]      w_sq;
    logic [EW-1:0]      r_s2_err;
    logic [WIDTH:0]     r_s2_abs;
    logic [PW-1:0]      r_s2_sq;
    logic               r_s2_valid;

    logic [CW-1:0]      r_err_count;
    logic [SW-1:0]      r_err_sum;
    logic [AW-1:0]      r_abs_sum;
    logic [QW-1:0]      r_sq_sum;
    logic [WIDTH:0]     r_max_abs;
    logic [CW-1:0]      r_total;

    assign w_accept = i_start && (r_state == IDLE || r_state == DONE);
    assign w_issue  = (r_state == RUN);
    assign w_last   = (r_cnt == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // DRAIN ends once stage 1 is empty: the last case then sits in stage 2 and
    // lands in the accumulators on the same edge that raises done.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE:  if (i_start) w_state_next = RUN;
            RUN:   if (w_last)  w_state_next = DRAIN;
            DRAIN: if (!r_s1_valid) begin
                w_state_next = DONE;
                w_done_next  = 1'b1;
            end
            DONE:  if (i_start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_mode <= MODE_EXACT;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_accept) begin
                r_cnt  <= '0;
                r_mode <= mode_e'(i_mode);
            end else if (w_issue) begin
                r_cnt <= r_cnt + STEP_ONE;
            end
        end
    end

    approx_add_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .i_a    (r_cnt[2*WIDTH-1:WIDTH]),
        .i_b    (r_cnt[WIDTH-1:0]),
        .i_mode (r_mode),
        .o_sum  (w_approx)
    );

    assign w_exact = {1'b0, r_cnt[2*WIDTH-1:WIDTH]} + {1'b0, r_cnt[WIDTH-1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_approx <= '0;
            r_s1_exact  <= '0;
        end else begin
            r_s1_valid  <= w_issue;
            r_s1_approx <= w_approx;
            r_s1_exact  <= w_exact;
        end
    end

    // |err| never reaches 2^(W+1), so negating the low W+1 bits gives the magnitude.
    assign w_err     = {1'b0, r_s1_approx} - {1'b0, r_s1_exact};
    assign w_abs     = w_err[EW-1] ? (~w_err[WIDTH:0] + ABS_ONE) : w_err[WIDTH:0];
    assign w_abs_ext = {{(WIDTH+1){1'b0}}, w_abs};
    assign w_sq      = w_abs_ext * w_abs_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= '0;
            r_s2_abs   <= '0;
            r_s2_sq    <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= w_err;
            r_s2_abs   <= w_abs;
            r_s2_sq    <= w_sq;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_abs_sum   <= '0;
            r_sq_sum    <= '0;
            r_max_abs   <= '0;
            r_total     <= '0;
        end else if (r_s2_valid) begin
            if (r_s2_err != '0) r_err_count <= r_err_count + CNT_ONE;
            r_err_sum <= r_err_sum + {{(SW-EW){r_s2_err[EW-1]}}, r_s2_err};
            r_abs_sum <= r_abs_sum + {{(AW-WIDTH-1){1'b0}}, r_s2_abs};
            r_sq_sum  <= r_sq_sum + {{(QW-PW){1'b0}}, r_s2_sq};
            if (r_s2_abs > r_max_abs) r_max_abs <= r_s2_abs;
            r_total   <= r_total + CNT_ONE;
        end
    end

    assign o_busy        = (r_state == RUN) || (r_state == DRAIN);
    assign o_done        = r_done;
    assign o_err_count   = r_err_count;
    assign o_err_sum     = r_err_sum;
    assign o_abs_sum     = r_abs_sum;
    assign o_sq_sum      = r_sq_sum;
    assign o_max_abs_err = r_max_abs;
    assign o_total_cases = r_total;

endmodule
